// File: rtl/iter_alu_pkg.sv
// Shared constants for the iterative calculator ALU: opcodes, FSM states,
// engine modes and the percentage divisor.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_POW = 3'b100;
    localparam logic [2:0] OP_PCT = 3'b101;

    localparam int unsigned PCT_DIVISOR = 100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        M_MUL = 1'b0,
        M_DIV = 1'b1
    } eng_mode_t;

endpackage

// File: rtl/iter_muldiv.sv
// Shared shift-add multiplier / restoring divider. o_ready and the result
// outputs reflect the final iteration combinationally, so a caller can
// register them (or chain a new i_go) on the same edge.
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(2*WIDTH+1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_go,
    input  eng_mode_t            i_mode,
    input  logic [2*WIDTH-1:0]   i_x,
    input  logic [WIDTH-1:0]     i_y,
    input  logic [CW-1:0]        i_nbits,
    output logic                 o_ready,
    output logic [3*WIDTH-1:0]   o_prod,
    output logic [2*WIDTH-1:0]   o_quot,
    output logic [WIDTH-1:0]     o_rem
);

    localparam int W2 = 2*WIDTH;
    localparam int W3 = 3*WIDTH;
    localparam logic [CW-1:0] TWO_W = CW'(W2);

    logic [CW-1:0]   r_cnt;
    eng_mode_t       r_mode;
    logic [W3-1:0]   r_p;
    logic [W3-1:0]   r_mc;
    logic [WIDTH-1:0] r_m;
    logic [W2-1:0]   r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_d;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_r_next;
    logic [W2-1:0]    w_q_next;
    logic [W3-1:0]    w_p_next;
    logic [CW-1:0]    w_align;

    // Partial remainder never exceeds the divisor, so WIDTH+1 bits suffice.
    assign w_shift  = {r_r, r_q[W2-1]};
    assign w_diff   = w_shift - {1'b0, r_d};
    assign w_ge     = (w_shift >= {1'b0, r_d});
    assign w_r_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_q_next = {r_q[W2-2:0], w_ge};
    assign w_p_next = r_m[0] ? (r_p + r_mc) : r_p;
    assign w_align  = TWO_W - i_nbits;

    assign o_ready = (r_cnt == CW'(1));
    assign o_prod  = w_p_next;
    assign o_quot  = w_q_next;
    assign o_rem   = w_r_next;

    // Operand load on i_go, otherwise one multiply or divide step per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_mode <= M_MUL;
            r_p    <= '0;
            r_mc   <= '0;
            r_m    <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_d    <= '0;
        end else if (i_go) begin
            r_cnt  <= i_nbits;
            r_mode <= i_mode;
            r_p    <= '0;
            r_mc   <= {{WIDTH{1'b0}}, i_x};
            r_m    <= i_y;
            r_q    <= i_x << w_align;
            r_r    <= '0;
            r_d    <= i_y;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_mode == M_MUL) begin
                r_p  <= w_p_next;
                r_mc <= r_mc << 1;
                r_m  <= r_m >> 1;
            end else begin
                r_q <= w_q_next;
                r_r <= w_r_next;
            end
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle calculator ALU: IDLE/EXEC/DONE handshake around a shared
// multiply/divide engine, with pow iteration, flags and optional saturation.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           opcode,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 ovf,
    output logic                 neg,
    output logic                 dz
);

    localparam int W2 = 2*WIDTH;
    localparam int W3 = 3*WIDTH;
    localparam int CW = $clog2(2*WIDTH+1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_quick;
    logic [WIDTH-1:0] r_pow_cnt;
    logic             r_pct_ph2;
    logic             r_ovf_acc;
    logic [W2-1:0]    r_result;
    logic [WIDTH-1:0] r_remainder;
    logic             r_ovf;
    logic             r_neg;
    logic             r_dz;
    logic             r_done;
    logic             r_busy;

    state_t           w_next_state;
    logic             w_eng_start;
    logic             w_go;
    eng_mode_t        w_mode;
    logic [W2-1:0]    w_x;
    logic [WIDTH-1:0] w_y;
    logic [CW-1:0]    w_nbits;
    logic             w_fin;
    logic [W2-1:0]    w_res;
    logic [WIDTH-1:0] w_rem;
    logic             w_ovf;
    logic             w_neg;
    logic             w_dz;
    logic [WIDTH-1:0] w_pow_cnt_next;
    logic             w_ovf_acc_next;
    logic             w_ph2_next;
    logic             w_ready;
    logic [W3-1:0]    w_prod;
    logic [W2-1:0]    w_quot;
    logic [WIDTH-1:0] w_eng_rem;
    logic             w_pow_ovf;

    // Zero-divisor div and zero-exponent pow finish in one cycle without the engine.
    assign w_eng_start = (opcode == OP_MUL) || (opcode == OP_PCT) ||
                         (((opcode == OP_DIV) || (opcode == OP_POW)) && (b != '0));
    assign w_pow_ovf   = r_ovf_acc || (w_prod[W3-1:W2] != '0);

    iter_muldiv #(.WIDTH(WIDTH), .CW(CW)) u_engine (
        .clk     (clk),
        .reset   (reset),
        .i_go    (w_go),
        .i_mode  (w_mode),
        .i_x     (w_x),
        .i_y     (w_y),
        .i_nbits (w_nbits),
        .o_ready (w_ready),
        .o_prod  (w_prod),
        .o_quot  (w_quot),
        .o_rem   (w_eng_rem)
    );

    // Next-state, engine sequencing and result selection.
    always_comb begin
        w_next_state   = r_state;
        w_go           = 1'b0;
        w_mode         = M_MUL;
        w_x            = '0;
        w_y            = '0;
        w_nbits        = CW'(WIDTH);
        w_fin          = 1'b0;
        w_res          = r_result;
        w_rem          = '0;
        w_ovf          = 1'b0;
        w_neg          = 1'b0;
        w_dz           = 1'b0;
        w_pow_cnt_next = r_pow_cnt;
        w_ovf_acc_next = r_ovf_acc;
        w_ph2_next     = r_pct_ph2;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state   = S_EXEC;
                    w_go           = w_eng_start;
                    w_mode         = (opcode == OP_DIV) ? M_DIV : M_MUL;
                    w_x            = (opcode == OP_POW) ? W2'(1) : {{WIDTH{1'b0}}, a};
                    w_y            = (opcode == OP_POW) ? a : b;
                    w_pow_cnt_next = b;
                    w_ovf_acc_next = 1'b0;
                    w_ph2_next     = 1'b0;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_EXEC: begin
                if (r_quick) begin
                    w_fin = 1'b1;
                    case (r_op)
                        OP_ADD: w_res = {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
                        OP_SUB: begin
                            w_res = {{WIDTH{1'b0}}, r_a} - {{WIDTH{1'b0}}, r_b};
                            w_neg = (r_a < r_b);
                        end
                        OP_DIV: begin
                            w_res = {W2{1'b1}};
                            w_rem = r_a;
                            w_dz  = 1'b1;
                        end
                        OP_POW:  w_res = W2'(1);
                        default: w_res = '0;
                    endcase
                end else if (w_ready) begin
                    case (r_op)
                        OP_MUL: begin
                            w_fin = 1'b1;
                            w_res = w_prod[W2-1:0];
                        end
                        OP_DIV: begin
                            w_fin = 1'b1;
                            w_res = w_quot;
                            w_rem = w_eng_rem;
                        end
                        OP_POW: begin
                            w_ovf_acc_next = w_pow_ovf;
                            if (r_pow_cnt == WIDTH'(1)) begin
                                w_fin = 1'b1;
                                w_ovf = w_pow_ovf;
                                w_res = (w_pow_ovf && SATURATE) ? {W2{1'b1}} : w_prod[W2-1:0];
                            end else begin
                                w_go           = 1'b1;
                                w_x            = w_prod[W2-1:0];
                                w_y            = r_a;
                                w_pow_cnt_next = r_pow_cnt - WIDTH'(1);
                            end
                        end
                        OP_PCT: begin
                            if (r_pct_ph2) begin
                                w_fin = 1'b1;
                                w_res = w_quot;
                            end else begin
                                w_go       = 1'b1;
                                w_mode     = M_DIV;
                                w_x        = w_prod[W2-1:0];
                                w_y        = WIDTH'(PCT_DIVISOR);
                                w_nbits    = CW'(W2);
                                w_ph2_next = 1'b1;
                            end
                        end
                        default: begin
                            w_fin = 1'b1;
                            w_res = '0;
                        end
                    endcase
                end else begin
                    w_next_state = S_EXEC;
                end
                if (w_fin) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, operand latches, held results and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_ADD;
            r_quick     <= 1'b0;
            r_pow_cnt   <= '0;
            r_pct_ph2   <= 1'b0;
            r_ovf_acc   <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b0;
            r_neg       <= 1'b0;
            r_dz        <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_busy    <= (w_next_state != S_IDLE);
            r_done    <= (w_next_state == S_DONE);
            r_pow_cnt <= w_pow_cnt_next;
            r_pct_ph2 <= w_ph2_next;
            r_ovf_acc <= w_ovf_acc_next;
            if ((r_state == S_IDLE) && start) begin
                r_a     <= a;
                r_b     <= b;
                r_op    <= opcode;
                r_quick <= !w_eng_start;
                r_ovf   <= 1'b0;
                r_neg   <= 1'b0;
                r_dz    <= 1'b0;
            end else if (w_fin) begin
                r_result    <= w_res;
                r_remainder <= w_rem;
                r_ovf       <= w_ovf;
                r_neg       <= w_neg;
                r_dz        <= w_dz;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign remainder = r_remainder;
    assign ovf       = r_ovf;
    assign neg       = r_neg;
    assign dz        = r_dz;

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: an arithmetic reference model predicts outputs every
// cycle for a truncating and a saturating instance; directed cases pin values.
module tb_iter_alu;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int W2 = 16;
    localparam longint unsigned MASK = 64'h0000_0000_0000_FFFF;

    logic clk = 1'b0;
    logic reset, start;
    logic [W-1:0] a, b;
    logic [2:0] opcode;

    logic busy0, done0, ovf0, neg0, dz0;
    logic busy1, done1, ovf1, neg1, dz1;
    logic [W2-1:0] result0, result1;
    logic [W-1:0]  rem0, rem1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // model state
    bit m_busy = 1'b0, m_done = 1'b0;
    int m_left = 0;
    longint unsigned e_res0 = 0, e_res1 = 0, e_rem = 0;
    bit e_ovf = 1'b0, e_neg = 1'b0, e_dz = 1'b0;
    longint unsigned p_res0 = 0, p_res1 = 0, p_rem = 0;
    bit p_ovf = 1'b0, p_neg = 1'b0, p_dz = 1'b0;

    iter_alu #(.WIDTH(W), .SATURATE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .opcode(opcode),
        .busy(busy0), .done(done0), .result(result0), .remainder(rem0),
        .ovf(ovf0), .neg(neg0), .dz(dz0));

    iter_alu #(.WIDTH(W), .SATURATE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .opcode(opcode),
        .busy(busy1), .done(done1), .result(result1), .remainder(rem1),
        .ovf(ovf1), .neg(neg1), .dz(dz1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_op(input logic [2:0] op, input longint unsigned x, input longint unsigned y,
                            output longint unsigned r0, output longint unsigned r1,
                            output longint unsigned rm, output bit ov, output bit ng,
                            output bit dzf, output int lat);
        longint unsigned acc;
        r0 = 0; rm = 0; ov = 0; ng = 0; dzf = 0; lat = 1;
        case (op)
            OP_ADD: r0 = x + y;
            OP_SUB: begin r0 = (x - y) & MASK; ng = (x < y); end
            OP_DIV: begin
                if (y == 0) begin dzf = 1; r0 = MASK; rm = x; end
                else begin r0 = x / y; rm = x % y; lat = W; end
            end
            OP_MUL: begin r0 = x * y; lat = W; end
            OP_POW: begin
                acc = 1;
                for (longint unsigned i = 0; i < y; i++) begin
                    acc = acc * x;
                    if ((acc >> W2) != 0) ov = 1;
                    acc = acc & MASK;
                end
                r0 = acc;
                if (y != 0) lat = int'(y) * W;
            end
            OP_PCT: begin r0 = (x * y) / 100; lat = 3 * W; end
            default: r0 = 0;
        endcase
        r1 = ov ? MASK : r0;
    endtask

    // Reference model: accepts start only when idle, counts latency, then shows results.
    always @(posedge clk) begin : model
        longint unsigned t0, t1, tr;
        bit tov, tng, tdz;
        int tl;
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
            e_res0 <= 0; e_res1 <= 0; e_rem <= 0;
            e_ovf <= 1'b0; e_neg <= 1'b0; e_dz <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0; m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_done <= 1'b1; m_left <= 0;
                e_res0 <= p_res0; e_res1 <= p_res1; e_rem <= p_rem;
                e_ovf <= p_ovf; e_neg <= p_neg; e_dz <= p_dz;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start) begin
            model_op(opcode, longint'(a), longint'(b), t0, t1, tr, tov, tng, tdz, tl);
            p_res0 <= t0; p_res1 <= t1; p_rem <= tr;
            p_ovf <= tov; p_neg <= tng; p_dz <= tdz;
            m_left <= tl; m_busy <= 1'b1;
            e_ovf <= 1'b0; e_neg <= 1'b0; e_dz <= 1'b0;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("busy0", busy0, m_busy);
        check("done0", done0, m_done);
        check("result0", result0, e_res0);
        check("rem0", rem0, e_rem);
        check("flags0", {ovf0, neg0, dz0}, {e_ovf, e_neg, e_dz});
        check("busy1", busy1, m_busy);
        check("done1", done1, m_done);
        check("result1", result1, e_res1);
        check("rem1", rem1, e_rem);
        check("flags1", {ovf1, neg1, dz1}, {e_ovf, e_neg, e_dz});
    end

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit scramble, output int lat);
        int k;
        bit found;
        found = 0;
        lat = -1;
        @(negedge clk); #1;
        opcode = op; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done0) begin found = 1; break; end
            if (scramble) begin
                #1;
                start = 1'($urandom_range(0, 1));
                a = W'($urandom); b = W'($urandom); opcode = 3'($urandom);
            end
        end
        start = 1'b0;
        check("done_timeout", found, 1);
        if (found) lat = cyc - k;
    endtask

    task automatic b2b(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input int gap);
        int t[$];
        @(negedge clk); #1;
        opcode = op; a = x; b = y; start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done0) t.push_back(cyc);
            if (t.size() == 3) break;
        end
        #1 start = 1'b0;
        check("b2b_count", t.size(), 3);
        if (t.size() == 3) begin
            check("b2b_gap1", t[1] - t[0], gap);
            check("b2b_gap2", t[2] - t[1], gap);
        end
    endtask

    initial begin
        int lat;
        int seen;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; opcode = OP_ADD;
        repeat (2) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_result", result0, 0);
        #1 reset = 1'b0;

        do_op(OP_ADD, 8'd200, 8'd100, 0, lat);
        check("add_res", result0, 16'h012C);
        check("add_lat", lat, 1);

        // reset during the 4th cycle of an 8-cycle multiply
        @(negedge clk); #1;
        opcode = OP_MUL; a = 8'd13; b = 8'd11; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rstmid_busy", busy0, 0);
        check("rstmid_result", result0, 16'h0000);
        check("rstmid_flags", {ovf0, neg0, dz0}, 3'b000);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done0) seen++;
        end
        check("rstmid_nodone", seen, 0);
        do_op(OP_MUL, 8'd13, 8'd11, 0, lat);
        check("mul_res", result0, 16'd143);
        check("mul_lat", lat, 8);

        do_op(OP_SUB, 8'd5, 8'd9, 0, lat);
        check("sub_res", result0, 16'hFFFC);
        check("sub_neg", neg0, 1);

        do_op(OP_DIV, 8'd200, 8'd7, 0, lat);
        check("div_res", result0, 16'd28);
        check("div_rem", rem0, 8'd4);
        check("div_lat", lat, 8);

        do_op(OP_DIV, 8'd200, 8'd0, 0, lat);
        check("dz_flag", dz0, 1);
        check("dz_res", result0, 16'hFFFF);
        check("dz_rem", rem0, 8'd200);
        check("dz_lat", lat, 1);

        do_op(OP_POW, 8'd3, 8'd5, 0, lat);
        check("pow_res", result0, 16'd243);
        check("pow_ovf", ovf0, 0);
        check("pow_lat", lat, 40);

        do_op(OP_POW, 8'd7, 8'd0, 0, lat);
        check("pow0_res", result0, 16'd1);
        check("pow0_lat", lat, 1);

        do_op(OP_POW, 8'd2, 8'd16, 0, lat);
        check("powov_ovf", ovf0, 1);
        check("powov_trunc", result0, 16'h0000);
        check("powov_sat", result1, 16'hFFFF);
        check("powov_lat", lat, 128);

        do_op(OP_PCT, 8'd200, 8'd50, 1, lat);
        check("pct_res", result0, 16'd100);
        check("pct_lat", lat, 24);

        do_op(3'b111, 8'd9, 8'd9, 0, lat);
        check("ill_res", result0, 16'd0);
        check("ill_lat", lat, 1);

        b2b(OP_ADD, 8'd1, 8'd2, 3);
        b2b(OP_MUL, 8'd17, 8'd3, 10);

        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = W'($urandom);
            if (rop == OP_POW) rb = W'($urandom_range(0, 10));
            if ((rop == OP_DIV) && ($urandom_range(0, 4) == 0)) rb = '0;
            do_op(rop, ra, rb, ($urandom_range(0, 3) == 0), lat);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
